// File: rtl/ex_alu_unit.sv
// EX-stage ALU: single-cycle arithmetic/logic/compare/branch ops, iterative shifts,
// valid/ready handshake on both sides so a stalled consumer holds the result.
module ex_alu_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal_op
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  localparam logic [4:0] OP_IDLE = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SLL  = 5'd3;
  localparam logic [4:0] OP_SLT  = 5'd4;
  localparam logic [4:0] OP_SLTU = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_BEQ  = 5'd11;
  localparam logic [4:0] OP_BNE  = 5'd12;
  localparam logic [4:0] OP_BLT  = 5'd13;
  localparam logic [4:0] OP_BGE  = 5'd14;
  localparam logic [4:0] OP_BLTU = 5'd15;
  localparam logic [4:0] OP_BGEU = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [XLEN-1:0] result_reg;
  logic            branch_reg;
  logic            illegal_reg;
  logic [4:0]      op_reg;
  logic [SHW-1:0]  remaining_reg;

  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_branch;
  logic            alu_illegal;
  logic            alu_is_shift;
  logic [SHW-1:0]  shamt;
  logic [SHW:0]    step_amt;
  logic [XLEN-1:0] shifted;

  assign accept = in_valid && in_ready;
  assign shamt  = src_b[SHW-1:0];

  // Single-cycle datapath; shift ops just pass src_a into the working register.
  always_comb begin
    alu_res      = '0;
    alu_branch   = 1'b0;
    alu_illegal  = 1'b0;
    alu_is_shift = 1'b0;
    case (alu_op)
      OP_IDLE: ;
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_res      = src_a;
        alu_is_shift = 1'b1;
      end
      OP_BEQ:  alu_branch = (src_a == src_b);
      OP_BNE:  alu_branch = (src_a != src_b);
      OP_BLT:  alu_branch = ($signed(src_a) < $signed(src_b));
      OP_BGE:  alu_branch = ($signed(src_a) >= $signed(src_b));
      OP_BLTU: alu_branch = (src_a < src_b);
      OP_BGEU: alu_branch = (src_a >= src_b);
      default: alu_illegal = 1'b1;
    endcase
  end

  // Per-cycle shift amount is min(SHIFT_STEP, remaining); SRA keeps the sign bit
  // of the working register, which is src_a's sign captured at accept.
  always_comb begin
    step_amt = ({1'b0, remaining_reg} < STEP) ? {1'b0, remaining_reg} : STEP;
    shifted  = result_reg;
    case (op_reg)
      OP_SLL:  shifted = result_reg << step_amt;
      OP_SRL:  shifted = result_reg >> step_amt;
      OP_SRA:  shifted = $signed(result_reg) >>> step_amt;
      default: shifted = result_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (alu_is_shift && (shamt != '0)) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if ({1'b0, remaining_reg} == step_amt) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg    <= '0;
      branch_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
      op_reg        <= OP_IDLE;
      remaining_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            result_reg    <= alu_res;
            branch_reg    <= alu_branch;
            illegal_reg   <= alu_illegal;
            op_reg        <= alu_op;
            remaining_reg <= alu_is_shift ? shamt : '0;
          end
        end
        ST_SHIFT: begin
          result_reg    <= shifted;
          remaining_reg <= remaining_reg - step_amt[SHW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign result       = result_reg;
  assign branch_taken = branch_reg;
  assign illegal_op   = illegal_reg;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Bench for ex_alu_unit: directed corner cases plus random ops checked against
// an arithmetic reference model, including latency, backpressure and reset abort.
module tb_ex_alu_unit;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            illegal_op;

  int total = 0;
  int bad   = 0;

  ex_alu_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_taken(branch_taken), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics written directly from the op table.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic bt, output logic il);
    int sh;
    sh = int'(b[4:0]);
    r  = 32'd0;
    bt = 1'b0;
    il = 1'b0;
    case (op)
      5'd0:  ;
      5'd1:  r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = a << sh;
      5'd4:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd5:  r = (a < b) ? 32'd1 : 32'd0;
      5'd6:  r = a ^ b;
      5'd7:  r = a >> sh;
      5'd8:  r = $signed(a) >>> sh;
      5'd9:  r = a | b;
      5'd10: r = a & b;
      5'd11: bt = (a == b);
      5'd12: bt = (a != b);
      5'd13: bt = ($signed(a) < $signed(b));
      5'd14: bt = ($signed(a) >= $signed(b));
      5'd15: bt = (a < b);
      5'd16: bt = (a >= b);
      default: il = 1'b1;
    endcase
  endfunction

  // Called and returns at a negedge; one full transaction with latency check.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] er;
    logic        eb;
    logic        ei;
    int          sh;
    int          exp_lat;
    int          lat;
    int          guard;
    model(op, a, b, er, eb, ei);
    sh = int'(b[4:0]);
    exp_lat = 1;
    if ((op == 5'd3 || op == 5'd7 || op == 5'd8) && sh != 0) exp_lat = 1 + (sh + STEP - 1) / STEP;
    guard = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_branch"}, 64'(branch_taken), 64'(eb));
    chk({tag, "_illegal"}, 64'(illegal_op), 64'(ei));
    $display("op=%0d a=%08h b=%08h -> result=%08h bt=%0b il=%0b lat=%0d", op, a, b, result,
             branch_taken, illegal_op, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic        stable;
    logic        quiet;
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    alu_op = 5'd0;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_branch", 64'(branch_taken), 64'd0);
    chk("reset_illegal", 64'(illegal_op), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    do_op(5'd1, 32'h7FFFFFFF, 32'h00000001, "add_wrap");
    do_op(5'd2, 32'h0, 32'h1, "sub_borrow");
    do_op(5'd4, 32'hFFFFFFFF, 32'h1, "slt_neg");
    do_op(5'd5, 32'hFFFFFFFF, 32'h1, "sltu_big");
    do_op(5'd8, 32'h80000000, 32'd31, "sra_31");
    do_op(5'd3, 32'h1, 32'h25, "sll_shamt_mask");
    do_op(5'd7, 32'hDEADBEEF, 32'h0, "srl_zero");
    do_op(5'd13, 32'hFFFFFFFF, 32'h0, "blt");
    do_op(5'd16, 32'hFFFFFFFF, 32'h0, "bgeu");
    do_op(5'd11, 32'd5, 32'd5, "beq");
    do_op(5'd12, 32'd5, 32'd5, "bne");
    do_op(5'd6, 32'h5, 32'h5, "xor");
    do_op(5'd0, 32'h1234, 32'h5678, "idle_code");
    do_op(5'd31, 32'h1234, 32'h5678, "illegal_31");

    // Backpressure: result must hold and a stray in_valid must be ignored.
    alu_op = 5'd1; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        alu_op = 5'd2; src_a = 32'd100; src_b = 32'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!(out_valid === 1'b1 && result === 32'd7 && in_ready === 1'b0 &&
            branch_taken === 1'b0 && illegal_op === 1'b0)) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_hold", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_idle", 64'(in_ready), 64'd1);
    chk("bp_release_ov", 64'(out_valid), 64'd0);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    chk("bp_pulse_ignored", 64'(quiet), 64'd1);
    $display("backpressure: held result=%08h", result);

    // Reset aborts an in-flight shift silently.
    alu_op = 5'd3; src_a = 32'h1; src_b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ov", 64'(out_valid), 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_result", 64'(result), 64'd0);
    quiet = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    chk("rst_mid_silent", 64'(quiet), 64'd1);
    $display("reset mid-shift: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    do_op(5'd20, 32'hFFFF0000, 32'h0000FFFF, "illegal_20");

    for (int n = 0; n < 60; n++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = $urandom;
      rb  = $urandom;
      if (n % 4 == 0) ra = rb;
      do_op(rop, ra, rb, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
